// File: rtl/z2_ac_pkg.sv
// Shared definitions for the Zorro II AutoConfig initiator: register indices,
// FSM encodings and the size-code decode helpers.
package z2_ac_pkg;

  localparam logic [7:0] AC_TYPE    = 8'h00;
  localparam logic [7:0] AC_SIZE    = 8'h01;
  localparam logic [7:0] AC_BASE_HI = 8'h24;
  localparam logic [7:0] AC_BASE_LO = 8'h25;
  localparam logic [7:0] AC_SHUTUP  = 8'h26;
  localparam logic [7:0] AC_SPACE   = 8'hE8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_TYPE,
    ST_RD_SIZE,
    ST_CALC,
    ST_WR_LO,
    ST_WR_HI,
    ST_WR_SHUT,
    ST_NEXT,
    ST_FIN
  } ac_state_e;

  typedef enum logic [1:0] {
    BC_IDLE,
    BC_SETUP,
    BC_STROBE,
    BC_RELEASE
  } bc_state_e;

  // Board size in 64K units
  function automatic logic [7:0] size_units(input logic [2:0] code);
    logic [7:0] u;
    case (code)
      3'd0:    u = 8'd128;
      3'd1:    u = 8'd1;
      3'd2:    u = 8'd2;
      3'd3:    u = 8'd4;
      3'd4:    u = 8'd8;
      3'd5:    u = 8'd16;
      3'd6:    u = 8'd32;
      default: u = 8'd64;
    endcase
    return u;
  endfunction

  function automatic logic size_is_io(input logic [2:0] code);
    return (code == 3'd1) || (code == 3'd2) || (code == 3'd3);
  endfunction

  // An 8M board can only ever sit at $200000, which is not 8M aligned, so it
  // aligns to the 2M granularity of the RAM window instead of its own size.
  function automatic logic [7:0] align_units(input logic [2:0] code);
    return (code == 3'd0) ? 8'd32 : size_units(code);
  endfunction

endpackage

// File: rtl/z2_bus_cycle.sv
// One 68k-style AutoConfig bus cycle: SETUP, STROBE (until DTACK or timeout),
// RELEASE. ack pulses during RELEASE with rdata/timeout valid.
module z2_bus_cycle
  import z2_ac_pkg::*;
#(
  parameter int TIMEOUT = 63
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req,
  input  logic        rw,
  input  logic [7:0]  idx,
  input  logic [3:0]  wdata,
  output logic        ack,
  output logic [3:0]  rdata,
  output logic        timeout,
  output logic [22:0] ADDR,
  output logic        AS_n,
  output logic        RW,
  output logic [3:0]  DOUT,
  input  logic [3:0]  DIN,
  input  logic        DTACK
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  bc_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             expired;

  assign expired = (cnt == CNT_LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= BC_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BC_IDLE:    if (req) state_nxt = BC_SETUP;
      BC_SETUP:   state_nxt = BC_STROBE;
      BC_STROBE:  if (DTACK || expired) state_nxt = BC_RELEASE;
      BC_RELEASE: state_nxt = BC_IDLE;
      default:    state_nxt = BC_IDLE;
    endcase
  end

  always_comb begin
    ack = (state == BC_RELEASE);
  end

  // Strobe is registered from the next state so AS_n is a clean flop output
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      AS_n    <= 1'b1;
      RW      <= 1'b1;
      ADDR    <= '0;
      DOUT    <= 4'hF;
      cnt     <= '0;
      rdata   <= '0;
      timeout <= 1'b0;
    end else begin
      AS_n <= (state_nxt != BC_STROBE);
      if (state == BC_IDLE && req) begin
        ADDR    <= {AC_SPACE, 7'd0, idx};
        RW      <= rw;
        DOUT    <= rw ? 4'hF : wdata;
        timeout <= 1'b0;
      end
      if (state == BC_SETUP) begin
        cnt <= '0;
      end else if (state == BC_STROBE) begin
        if (DTACK)        rdata   <= DIN;
        else if (expired) timeout <= 1'b1;
        else              cnt     <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/zorro2_autoconfig_master.sv
// Zorro II AutoConfig initiator: walks the $E8 config chain, allocates each
// board a size-aligned base in the RAM or I/O window, or shuts it up.
module zorro2_autoconfig_master
  import z2_ac_pkg::*;
#(
  parameter int         MAX_BOARDS = 4,
  parameter logic [7:0] RAM_LO     = 8'h20,
  parameter logic [7:0] RAM_HI     = 8'hA0,
  parameter logic [7:0] IO_LO      = 8'hE9,
  parameter logic [7:0] IO_HI      = 8'hF0,
  parameter int         TIMEOUT    = 63
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [22:0] ADDR,
  output logic        AS_n,
  output logic        RW,
  output logic [3:0]  DOUT,
  input  logic [3:0]  DIN,
  input  logic        DTACK,
  output logic        cfg_valid,
  output logic [7:0]  cfg_base,
  output logic [2:0]  cfg_size,
  output logic        cfg_shut,
  output logic [2:0]  board_count
);

  ac_state_e  state, state_nxt;

  logic       bc_req, bc_rw, bc_ack, bc_timeout;
  logic [7:0] bc_idx;
  logic [3:0] bc_wdata, bc_rdata;

  logic [7:0] ram_ptr, io_ptr, next_ptr;
  logic       win_io, last_board;
  logic [7:0] ptr, win_hi, units, al;
  logic [8:0] al_mask, calc_aligned;
  logic [9:0] calc_end;
  logic       calc_fit;

  z2_bus_cycle #(.TIMEOUT(TIMEOUT)) u_bus (
    .CLK     (CLK),
    .RESET   (RESET),
    .req     (bc_req),
    .rw      (bc_rw),
    .idx     (bc_idx),
    .wdata   (bc_wdata),
    .ack     (bc_ack),
    .rdata   (bc_rdata),
    .timeout (bc_timeout),
    .ADDR    (ADDR),
    .AS_n    (AS_n),
    .RW      (RW),
    .DOUT    (DOUT),
    .DIN     (DIN),
    .DTACK   (DTACK)
  );

  // Allocation: 9-bit arithmetic so a carry past $FF reads as no-fit
  always_comb begin
    win_io       = size_is_io(cfg_size);
    ptr          = win_io ? io_ptr : ram_ptr;
    win_hi       = win_io ? IO_HI : RAM_HI;
    units        = size_units(cfg_size);
    al           = align_units(cfg_size);
    al_mask      = {1'b0, al} - 9'd1;
    calc_aligned = ({1'b0, ptr} + al_mask) & ~al_mask;
    calc_end     = {1'b0, calc_aligned} + {2'b00, units};
    calc_fit     = !calc_aligned[8] && (calc_end <= {2'b00, win_hi});
    last_board   = ({1'b0, board_count} + 4'd1) == 4'(MAX_BOARDS);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_RD_TYPE;
      ST_RD_TYPE: if (bc_ack) state_nxt = (bc_timeout || bc_rdata[3:2] != 2'b11) ? ST_FIN : ST_RD_SIZE;
      ST_RD_SIZE: if (bc_ack) state_nxt = bc_timeout ? ST_FIN : ST_CALC;
      ST_CALC:    state_nxt = calc_fit ? ST_WR_LO : ST_WR_SHUT;
      ST_WR_LO:   if (bc_ack) state_nxt = bc_timeout ? ST_FIN : ST_WR_HI;
      ST_WR_HI:   if (bc_ack) state_nxt = bc_timeout ? ST_FIN : ST_NEXT;
      ST_WR_SHUT: if (bc_ack) state_nxt = bc_timeout ? ST_FIN : ST_NEXT;
      ST_NEXT:    state_nxt = last_board ? ST_FIN : ST_RD_TYPE;
      ST_FIN:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE) && (state != ST_FIN);
    cfg_valid = (state == ST_NEXT);
    bc_req    = 1'b0;
    bc_rw     = 1'b1;
    bc_idx    = AC_TYPE;
    bc_wdata  = 4'hF;
    case (state)
      ST_RD_TYPE: bc_req = 1'b1;
      ST_RD_SIZE: begin bc_req = 1'b1; bc_idx = AC_SIZE; end
      ST_WR_LO:   begin bc_req = 1'b1; bc_rw = 1'b0; bc_idx = AC_BASE_LO; bc_wdata = cfg_base[3:0]; end
      ST_WR_HI:   begin bc_req = 1'b1; bc_rw = 1'b0; bc_idx = AC_BASE_HI; bc_wdata = cfg_base[7:4]; end
      ST_WR_SHUT: begin bc_req = 1'b1; bc_rw = 1'b0; bc_idx = AC_SHUTUP; end
      default:    ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ram_ptr     <= RAM_LO;
      io_ptr      <= IO_LO;
      next_ptr    <= '0;
      board_count <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      cfg_base    <= '0;
      cfg_size    <= '0;
      cfg_shut    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          ram_ptr     <= RAM_LO;
          io_ptr      <= IO_LO;
          board_count <= '0;
          done        <= 1'b0;
          error       <= 1'b0;
        end
        ST_RD_SIZE: if (bc_ack && !bc_timeout) cfg_size <= bc_rdata[2:0];
        ST_CALC: begin
          cfg_base <= calc_fit ? calc_aligned[7:0] : 8'h00;
          cfg_shut <= !calc_fit;
          next_ptr <= calc_end[7:0];
        end
        // Writing the high nibble commits the board, so only then advance
        ST_WR_HI: if (bc_ack && !bc_timeout) begin
          if (win_io) io_ptr  <= next_ptr;
          else        ram_ptr <= next_ptr;
        end
        ST_NEXT: board_count <= board_count + 3'd1;
        default: ;
      endcase
      if (bc_ack && bc_timeout && state != ST_RD_TYPE) error <= 1'b1;
      if (state != ST_FIN && state_nxt == ST_FIN)    done  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_zorro2_autoconfig_master.sv
// Bench for the AutoConfig initiator: behavioural responder chain plus
// scoreboards for bus writes and cfg_valid reports.
module tb_zorro2_autoconfig_master;

  logic        CLK = 1'b0;
  logic        RESET, start;
  logic        busy, done, error;
  logic [22:0] ADDR;
  logic        AS_n, RW;
  logic [3:0]  DOUT, DIN;
  logic        DTACK;
  logic        cfg_valid;
  logic [7:0]  cfg_base;
  logic [2:0]  cfg_size;
  logic        cfg_shut;
  logic [2:0]  board_count;

  always #5 CLK = ~CLK;

  zorro2_autoconfig_master dut (
    .CLK(CLK), .RESET(RESET), .start(start), .busy(busy), .done(done), .error(error),
    .ADDR(ADDR), .AS_n(AS_n), .RW(RW), .DOUT(DOUT), .DIN(DIN), .DTACK(DTACK),
    .cfg_valid(cfg_valid), .cfg_base(cfg_base), .cfg_size(cfg_size), .cfg_shut(cfg_shut),
    .board_count(board_count)
  );

  typedef struct packed {
    logic [3:0]  n;     // boards present in the chain
    logic [31:0] typ;   // nibble i = type of board i
    logic [31:0] sz;    // nibble i = size code of board i
    logic [63:0] base;  // byte i = expected cfg_base (00 = shut up)
    logic [3:0]  cnt;   // expected board_count
    logic        err;
  } vec_t;

  vec_t vecs[10];

  int total = 0;
  int bad   = 0;

  logic [11:0] exp_wr[$];
  logic [11:0] exp_cfg[$];

  logic [3:0] rb_typ[8];
  logic [2:0] rb_sz[8];
  int         rb_n = 0;
  int         gen = 0;
  logic [7:0] withhold = 8'hFF;

  int cur = 0, seen_gen = 0, lowcnt = 0;
  bit acked = 0, adv = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Responder chain and cfg monitor, both sampled on the falling edge
  initial begin
    DTACK = 1'b0;
    DIN   = 4'h0;
    forever begin
      @(negedge CLK);
      DTACK = 1'b0;
      if (gen != seen_gen) begin
        seen_gen = gen; cur = 0; adv = 0; lowcnt = 0;
      end
      if (AS_n) begin
        if (adv) cur++;
        adv = 0; acked = 0;
      end else begin
        if (ADDR[7:0] == withhold) lowcnt++;
        if (!acked && cur < rb_n && ADDR[7:0] != withhold) begin
          acked = 1; DTACK = 1'b1;
          check("bus space", {17'd0, ADDR[22:8]}, 32'h7400);
          if (RW) begin
            DIN = (ADDR[7:0] == 8'h00) ? rb_typ[cur] :
                  (ADDR[7:0] == 8'h01) ? {1'b0, rb_sz[cur]} : 4'hF;
          end else begin
            check("write expected", exp_wr.size() != 0, 1);
            if (exp_wr.size() != 0) check("write idx/data", {ADDR[7:0], DOUT}, exp_wr.pop_front());
            if (ADDR[7:0] == 8'h24 || ADDR[7:0] == 8'h26) adv = 1;
          end
        end
      end
      if (!RESET && cfg_valid) begin
        check("cfg expected", exp_cfg.size() != 0, 1);
        if (exp_cfg.size() != 0) check("cfg base/size/shut", {cfg_base, cfg_size, cfg_shut}, exp_cfg.pop_front());
      end
    end
  end

  task automatic load(input vec_t v, input logic [7:0] wh);
    for (int i = 0; i < 8; i++) begin
      rb_typ[i] = v.typ[i*4 +: 4];
      rb_sz[i]  = v.sz[i*4 +: 3];
    end
    rb_n = int'(v.n);
    withhold = wh;
    gen++;
    exp_wr.delete();
    exp_cfg.delete();
  endtask

  task automatic push_expect(input vec_t v);
    logic [7:0] b;
    for (int i = 0; i < int'(v.cnt); i++) begin
      b = v.base[i*8 +: 8];
      exp_cfg.push_back({b, v.sz[i*4 +: 3], b == 8'h00});
      if (b != 8'h00) begin
        exp_wr.push_back({8'h25, b[3:0]});
        exp_wr.push_back({8'h24, b[7:4]});
      end else begin
        exp_wr.push_back({8'h26, 4'hF});
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge CLK);
      if (done) ok = 1;
    end
    check({nm, " done reached"}, ok, 1);
  endtask

  task automatic check_reset(input string nm);
    check({nm, " AS_n"}, AS_n, 1);
    check({nm, " RW"}, RW, 1);
    check({nm, " ADDR"}, ADDR, 0);
    check({nm, " DOUT"}, DOUT, 4'hF);
    check({nm, " busy"}, busy, 0);
    check({nm, " done"}, done, 0);
    check({nm, " error"}, error, 0);
    check({nm, " cfg_valid"}, cfg_valid, 0);
    check({nm, " cfg_base"}, cfg_base, 0);
    check({nm, " cfg_size"}, cfg_size, 0);
    check({nm, " cfg_shut"}, cfg_shut, 0);
    check({nm, " board_count"}, board_count, 0);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    string nm;
    nm = $sformatf("v%0d", k);
    load(v, 8'hFF);
    push_expect(v);
    pulse_start();
    check({nm, " busy after start"}, busy, 1);
    check({nm, " done cleared"}, done, 0);
    repeat (2) @(negedge CLK);
    start = 1'b1;  // must be ignored while busy
    @(negedge CLK) start = 1'b0;
    wait_done(nm);
    check({nm, " busy at end"}, busy, 0);
    check({nm, " error"}, error, v.err);
    check({nm, " board_count"}, board_count, v.cnt);
    check({nm, " writes left"}, exp_wr.size(), 0);
    check({nm, " cfgs left"}, exp_cfg.size(), 0);
  endtask

  initial begin
    bit ok;
    RESET = 1'b1;
    start = 1'b0;
    vecs[0] = '{n:4'd1, typ:32'hE,     sz:32'h0,     base:64'h20,       cnt:4'd1, err:1'b0};
    vecs[1] = '{n:4'd3, typ:32'hEEE,   sz:32'h210,   base:64'hEAE920,   cnt:4'd3, err:1'b0};
    vecs[2] = '{n:4'd3, typ:32'hEEE,   sz:32'h121,   base:64'hECEAE9,   cnt:4'd3, err:1'b0};
    vecs[3] = '{n:4'd2, typ:32'hEE,    sz:32'h67,    base:64'h8040,     cnt:4'd2, err:1'b0};
    vecs[4] = '{n:4'd2, typ:32'hEE,    sz:32'h00,    base:64'h0020,     cnt:4'd2, err:1'b0};
    vecs[5] = '{n:4'd0, typ:32'h0,     sz:32'h0,     base:64'h0,        cnt:4'd0, err:1'b0};
    vecs[6] = '{n:4'd5, typ:32'hEEEEE, sz:32'h11111, base:64'hECEBEAE9, cnt:4'd4, err:1'b0};
    vecs[7] = '{n:4'd1, typ:32'hA,     sz:32'h1,     base:64'h0,        cnt:4'd0, err:1'b0};
    vecs[8] = '{n:4'd4, typ:32'hEEEE,  sz:32'h1321,  base:64'h00ECEAE9, cnt:4'd4, err:1'b0};
    vecs[9] = '{n:4'd3, typ:32'hCEE,   sz:32'h607,   base:64'h800040,   cnt:4'd3, err:1'b0};

    repeat (3) @(negedge CLK);
    check_reset("reset");
    RESET = 1'b0;

    for (int k = 0; k < 10; k++) run_vec(vecs[k], k);

    // DTACK withheld on the base-high write
    load(vecs[0], 8'h24);
    exp_wr.push_back({8'h25, 4'h0});
    pulse_start();
    wait_done("wrhi timeout");
    check("wrhi timeout error", error, 1);
    check("wrhi timeout board_count", board_count, 0);
    check("wrhi timeout AS_n low clks", lowcnt, 63);
    check("wrhi timeout writes left", exp_wr.size(), 0);

    // Asynchronous reset in the middle of a strobe, after one board committed
    load(vecs[1], 8'hFF);
    push_expect(vecs[1]);
    pulse_start();
    ok = 0;
    begin
      bit seen = 0;
      for (int i = 0; i < 500 && !ok; i++) begin
        @(negedge CLK);
        if (cfg_valid) seen = 1;
        if (seen && !AS_n) ok = 1;
      end
    end
    check("reach mid-cycle strobe", ok, 1);
    #2 RESET = 1'b1;
    #1 check_reset("async reset");
    @(negedge CLK) RESET = 1'b0;
    run_vec(vecs[1], 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
